arb_requester: RTL and testbench

- Upstream stage of the 2-client fixed-priority arbiter: queues per-client burst commands and drives the arbiter's 2-bit request vector.
- Consumes the arbiter's registered grant and emits per-client beat strobes while a burst owns the resource.
- Handles the arbiter's one-cycle grant latency and preemption of client 0 by client 1.

---
 rtl/arb_pkg.sv | 16 +
 rtl/arb_cmd_fifo.sv | 61 ++++++
 rtl/arb_requester.sv | 126 ++++++++++++
 tb/tb_arb_requester.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and encodings for the 2-client arbiter requester slice.
package arb_pkg;

    localparam int NUM_CLIENTS = 2;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] GNT_C0   = 2'b01;
    localparam logic [1:0] GNT_C1   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } req_state_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Per-client burst-length command FIFO with show-ahead read data.
module arb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [LEN_W-1:0] push_data,
    input  logic             pop,
    output logic [LEN_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [LEN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Full blocks a push even when a pop happens in the same cycle.
    assign full     = (count_reg == FULL_CNT);
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Upstream requester for the 2-client fixed-priority arbiter: queues bursts, drives request, emits beats.
// Optional macro ARB_REQ_NO_PREEMPT_EN makes client 0 bursts atomic by holding off client 1's request.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         cmd_valid,
    input  logic [2*LEN_W-1:0] cmd_len,
    output logic [1:0]         cmd_ready,
    output logic [1:0]         request,
    input  logic [1:0]         grant,
    output logic [1:0]         beat_valid,
    output logic [1:0]         beat_last,
    output logic [1:0]         busy
);

    localparam logic [LEN_W:0] BEAT_ONE = (LEN_W + 1)'(1);

    logic [1:0] req_int;

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        logic [LEN_W-1:0] fifo_data;
        logic             fifo_full;
        logic             fifo_empty;
        logic             fifo_pop;
        logic             granted;
        logic             req_c;
        logic             bv_c;
        logic             bl_c;
        req_state_t       state_reg;
        req_state_t       state_next;
        logic [LEN_W:0]   beats_left_reg;
        logic [LEN_W:0]   beats_left_next;

        // X or Z on the grant line must never be taken as a grant.
        assign granted = (grant[gi] === 1'b1);

        arb_cmd_fifo #(
            .DEPTH (DEPTH),
            .LEN_W (LEN_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (cmd_valid[gi]),
            .push_data (cmd_len[gi*LEN_W +: LEN_W]),
            .pop       (fifo_pop),
            .pop_data  (fifo_data),
            .full      (fifo_full),
            .empty     (fifo_empty)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_reg      <= IDLE;
                beats_left_reg <= '0;
            end else begin
                state_reg      <= state_next;
                beats_left_reg <= beats_left_next;
            end
        end

        always_comb begin
            state_next      = state_reg;
            beats_left_next = beats_left_reg;
            fifo_pop        = 1'b0;
            req_c           = 1'b0;
            bv_c            = 1'b0;
            bl_c            = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop        = 1'b1;
                        beats_left_next = (LEN_W + 1)'(fifo_data) + BEAT_ONE;
                        state_next      = REQ;
                    end
                end
                REQ: begin
                    req_c = 1'b1;
                    if (granted) begin
                        bv_c            = 1'b1;
                        beats_left_next = beats_left_reg - BEAT_ONE;
                        if (beats_left_reg == BEAT_ONE) begin
                            bl_c       = 1'b1;
                            state_next = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // Grant lags request by a cycle; wait it out with beats masked.
                    if (!granted) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        assign req_int[gi]    = req_c;
        assign beat_valid[gi] = bv_c;
        assign beat_last[gi]  = bl_c;
        assign cmd_ready[gi]  = !fifo_full;
        assign busy[gi]       = !fifo_empty || (state_reg != IDLE);
    end

`ifdef ARB_REQ_NO_PREEMPT_EN
    logic owned_reg;

    // Client 0 owns the resource from its first beat up to and including its last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owned_reg <= 1'b0;
        end else if (beat_valid[0]) begin
            owned_reg <= !beat_last[0];
        end
    end

    assign request = {req_int[1] && !owned_reg, req_int[0]};
`else
    assign request = req_int;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Randomised and directed bench for arb_requester against a registered fixed-priority arbiter model.
module tb_arb_requester;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         cmd_valid = 2'b00;
    logic [2*LEN_W-1:0] cmd_len = '0;
    logic [1:0]         cmd_ready;
    logic [1:0]         request;
    logic [1:0]         grant;
    logic [1:0]         beat_valid;
    logic [1:0]         beat_last;
    logic [1:0]         busy;
    logic               gnt1_en = 1'b1;

    int checks = 0;
    int errors = 0;

    // Expected beat_last flag per outstanding beat, in order, per client.
    bit q0[$];
    bit q1[$];

    int         beat_cnt [2];
    int         first_cyc [2];
    int         last_cyc [2];
    bit         in_burst [2];
    int         c0_beat_cyc[$];
    logic [1:0] req_hist[$];
    int         c1_rise_cyc = -1;
    bit         prev_req1 = 1'b0;
    bit         exp_last;

    arb_requester #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .request    (request),
        .grant      (grant),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Arbiter: registered, client 1 highest priority; client 1 can be gated off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant <= 2'b00;
        end else if (request[1] && gnt1_en) begin
            grant <= 2'b10;
        end else if (request[0]) begin
            grant <= 2'b01;
        end else begin
            grant <= 2'b00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every beat is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            req_hist.push_back(request);
            for (int i = 0; i < 2; i++) begin
                if (beat_valid[i]) begin
                    check($sformatf("beat_req_c%0d", i), 32'(request[i]), 32'd1);
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat_c%0d: got beat with last=%0b required no beat", i, beat_last[i]);
                    end else begin
                        if (i == 0) exp_last = q0.pop_front();
                        else        exp_last = q1.pop_front();
                        check($sformatf("beat_last_c%0d", i), 32'(beat_last[i]), 32'(exp_last));
                    end
                    beat_cnt[i]++;
                    if (!in_burst[i]) begin
                        first_cyc[i] = req_hist.size() - 1;
                        in_burst[i]  = 1'b1;
                    end
                    if (beat_last[i]) begin
                        last_cyc[i] = req_hist.size() - 1;
                        in_burst[i] = 1'b0;
                    end
                    if (i == 0) c0_beat_cyc.push_back(req_hist.size() - 1);
                end else if (beat_last[i]) begin
                    check($sformatf("last_without_valid_c%0d", i), 32'(beat_last[i]), 32'd0);
                end
            end
            if (request[1] && !prev_req1) c1_rise_cyc = req_hist.size() - 1;
            prev_req1 = request[1];
        end
    end

    task automatic drive(input logic [1:0] v, input logic [2*LEN_W-1:0] lens, output logic [1:0] acc);
        @(negedge clk);
        cmd_valid = v;
        cmd_len   = lens;
        acc       = v & cmd_ready;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                int len;
                len = int'(lens[i*LEN_W +: LEN_W]);
                for (int b = 0; b <= len; b++) begin
                    if (i == 0) q0.push_back(b == len);
                    else        q1.push_back(b == len);
                end
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 2'b00;
    endtask

    task automatic push(input int c, input int len, output bit acc);
        logic [1:0]         v;
        logic [2*LEN_W-1:0] lens;
        logic [1:0]         a;
        v = 2'b00;
        v[c] = 1'b1;
        lens = '0;
        lens[c*LEN_W +: LEN_W] = LEN_W'(len);
        drive(v, lens, a);
        acc = a[c];
    endtask

    task automatic wait_beats(input int c, input int target, input string name);
        int n = 0;
        while (beat_cnt[c] < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        check({name, "_wait"}, 32'(beat_cnt[c] >= target), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy != 2'b00) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_pending"}, 32'(q0.size() + q1.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit         acc;
        logic [1:0] acc2;
        logic [8:0] t_req  = 9'b000011110;
        logic [8:0] t_bv   = 9'b000011100;
        logic [8:0] t_bl   = 9'b000010000;
        logic [8:0] t_busy = 9'b001111111;
        logic [5:0] exp_acc = 6'b011111;
        int b0;
        int b1;
        int n;
        int s;
        int lo;

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("por_request", 32'(request), 32'd0);
        check("por_beat_valid", 32'(beat_valid), 32'd0);
        check("por_beat_last", 32'(beat_last), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        check("por_cmd_ready", 32'(cmd_ready), 32'd3);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single client 0 burst of 3 beats, traced cycle by cycle from the push edge.
        push(0, 2, acc);
        check("t2_accept", 32'(acc), 32'd1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("t2_request_k%0d", k), 32'(request), 32'(t_req[k]));
            check($sformatf("t2_beat_valid_k%0d", k), 32'(beat_valid), 32'(t_bv[k]));
            check($sformatf("t2_beat_last_k%0d", k), 32'(beat_last), 32'(t_bl[k]));
            check($sformatf("t2_busy_k%0d", k), 32'(busy), 32'(t_busy[k]));
        end
        drain("t2");

        // Asynchronous reset in the middle of a burst with 3 beats left.
        b0 = beat_cnt[0];
        push(0, 4, acc);
        wait_beats(0, b0 + 2, "t1");
        #2 rst = 1'b0;
        q0.delete();
        q1.delete();
        in_burst[0] = 1'b0;
        in_burst[1] = 1'b0;
        #1;
        check("t1_request", 32'(request), 32'd0);
        check("t1_beat_valid", 32'(beat_valid), 32'd0);
        check("t1_beat_last", 32'(beat_last), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_cmd_ready", 32'(cmd_ready), 32'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        b0 = beat_cnt[0];
        repeat (10) @(negedge clk);
        check("t1_no_beats_after", 32'(beat_cnt[0] - b0), 32'd0);

        // Client 0 long burst with client 1 arriving after client 0's second beat.
        b0 = beat_cnt[0];
        b1 = beat_cnt[1];
        push(0, 7, acc);
        wait_beats(0, b0 + 2, "t3");
        push(1, 1, acc);
        drain("t3");
        check("t3_c0_beats", 32'(beat_cnt[0] - b0), 32'd8);
        check("t3_c1_beats", 32'(beat_cnt[1] - b1), 32'd2);
`ifdef ARB_REQ_NO_PREEMPT_EN
        check("t4_c0_contiguous", 32'(last_cyc[0] - first_cyc[0]), 32'd7);
        check("t4_c1_req_after_last", 32'(c1_rise_cyc), 32'(last_cyc[0] + 1));
`else
        check("t3_c1_inside_c0", 32'(first_cyc[0] < last_cyc[1] && last_cyc[1] < last_cyc[0]), 32'd1);
        check("t3_c0_paused", 32'(last_cyc[0] - first_cyc[0] > 7), 32'd1);
`endif

        // FIFO full: one command sits in the stalled FSM, so DEPTH+1 pushes are taken.
        gnt1_en = 1'b0;
        b1 = beat_cnt[1];
        for (int p = 0; p < 6; p++) begin
            push(1, p + 1, acc);
            check($sformatf("t5_accept_%0d", p), 32'(acc), 32'(exp_acc[p]));
        end
        @(negedge clk);
        check("t5_cmd_ready", 32'(cmd_ready[1]), 32'd0);
        check("t5_request", 32'(request[1]), 32'd1);
        check("t5_no_beat", 32'(beat_valid[1]), 32'd0);
        check("t5_busy", 32'(busy[1]), 32'd1);
        gnt1_en = 1'b1;
        drain("t5");
        check("t5_c1_beats", 32'(beat_cnt[1] - b1), 32'd20);

        // Back-to-back single-beat commands on client 0.
        c0_beat_cyc.delete();
        push(0, 0, acc);
        push(0, 0, acc);
        drain("t6");
        check("t6_two_beats", 32'(c0_beat_cyc.size()), 32'd2);
        if (c0_beat_cyc.size() == 2) begin
            s  = c0_beat_cyc[1] - c0_beat_cyc[0];
            lo = 0;
            for (int c = c0_beat_cyc[0] + 1; c < c0_beat_cyc[1]; c++) begin
                if (req_hist[c][0] == 1'b0) lo++;
            end
            check("t6_spacing", 32'(s), 32'd5);
            check("t6_req_gap", 32'(lo >= 1), 32'd1);
        end

        // Random traffic on both clients.
        n = 0;
        for (int r = 0; r < 80; r++) begin
            logic [1:0]         v;
            logic [2*LEN_W-1:0] lens;
            v[0] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 4) == 0);
            lens = {LEN_W'($urandom_range(0, 3)), LEN_W'($urandom_range(0, 3))};
            drive(v, lens, acc2);
            n += int'(acc2[0]) + int'(acc2[1]);
        end
        check("rand_some_accepted", 32'(n > 0), 32'd1);
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
